// File: rtl/div_if.sv
// Execute-stage divide request/result bundle shared between EX and the divide sequencer.
interface div_if #(parameter int DATA_W = 32);
    logic                  start_i;
    logic                  annul_i;
    logic                  signed_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stall_o;

    modport master (
        output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, stall_o
    );

    modport slave (
        input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        output result_o, ready_o, stall_o
    );
endinterface

// File: rtl/div_sched.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock, sign fix at the end,
// {remainder, quotient} held for the HI/LO write while the pipeline is stalled.
//
// state  | meaning
// IDLE   | waiting for a divide request; result holds, ready low
// BYZERO | divisor was zero; result forced to 0 on the next edge
// ON     | one shift/subtract iteration per edge, sign fix after the last
// END    | result valid; stays until EX drops start or annuls
module div_sched #(
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  sgn;
    logic                  dvd_neg;
    logic                  dvs_neg;
    logic [DATA_W-1:0]     dvs;
    logic [DATA_W-1:0]     rem;
    logic [DATA_W-1:0]     quo;
    logic [2*DATA_W-1:0]   result;
    logic                  ready;

    logic                  abort;
    logic [DATA_W-1:0]     mag1;
    logic [DATA_W-1:0]     mag2;
    logic [DATA_W:0]       rem_sh;
    logic [DATA_W:0]       diff;
    logic [DATA_W-1:0]     quo_fix;
    logic [DATA_W-1:0]     rem_fix;

    always_comb begin
        abort   = bus.annul_i | ~bus.start_i;
        mag1    = (bus.signed_i & bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
        mag2    = (bus.signed_i & bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
        // Remainder is always below the divisor, so the shifted value fits in DATA_W+1 bits.
        rem_sh  = {rem, quo[DATA_W-1]};
        diff    = rem_sh - {1'b0, dvs};
        quo_fix = (sgn & (dvd_neg ^ dvs_neg)) ? -quo : quo;
        rem_fix = (sgn & dvd_neg) ? -rem : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sgn     <= 1'b0;
            dvd_neg <= 1'b0;
            dvs_neg <= 1'b0;
            dvs     <= '0;
            rem     <= '0;
            quo     <= '0;
            result  <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (bus.start_i & ~bus.annul_i) begin
                        sgn     <= bus.signed_i;
                        dvd_neg <= bus.signed_i & bus.opdata1_i[DATA_W-1];
                        dvs_neg <= bus.signed_i & bus.opdata2_i[DATA_W-1];
                        if (bus.opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            dvs   <= mag2;
                            rem   <= '0;
                            quo   <= mag1;
                            cnt   <= '0;
                            state <= ON;
                        end
                    end
                end
                BYZERO: begin
                    result <= '0;
                    ready  <= 1'b1;
                    state  <= END;
                end
                ON: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (cnt == CNT_W'(DATA_W)) begin
                        result <= {rem_fix, quo_fix};
                        ready  <= 1'b1;
                        state  <= END;
                    end else begin
                        rem <= diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], ~diff[DATA_W]};
                        cnt <= cnt + 1'b1;
                    end
                end
                END: begin
                    if (abort) begin
                        ready <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result_o = result;
    assign bus.ready_o  = ready;
    assign bus.stall_o  = ~rst & bus.start_i & ~bus.annul_i & ~ready;
endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: arithmetic reference model checked every cycle plus literal results.
module tb_div_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    div_if #(.DATA_W(32)) bus ();

    div_sched #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Truncating division on 64-bit integers, so INT_MIN / -1 needs no special case.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    logic        m_ready  = 1'b0;
    logic        m_busy   = 1'b0;
    logic        m_zero   = 1'b0;
    int          m_left   = 0;
    logic [63:0] m_res    = 64'd0;
    logic [63:0] m_target = 64'd0;

    // Reference: a request produces its result 33 edges later (1 for a zero divisor) unless
    // withdrawn first; the result then stays valid until the request is withdrawn.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready <= 1'b0;
            m_busy  <= 1'b0;
            m_left  <= 0;
            m_res   <= 64'd0;
        end else if (m_ready) begin
            if (!bus.start_i || bus.annul_i) m_ready <= 1'b0;
        end else if (m_busy) begin
            if (m_zero) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                m_res   <= 64'd0;
            end else if (!bus.start_i || bus.annul_i) begin
                m_busy <= 1'b0;
            end else if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                m_res   <= m_target;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (bus.start_i && !bus.annul_i) begin
            m_busy   <= 1'b1;
            m_zero   <= (bus.opdata2_i == 32'd0);
            m_left   <= 33;
            m_target <= ref_div(bus.signed_i, bus.opdata1_i, bus.opdata2_i);
        end
    end

    always @(negedge clk) begin
        if (rst || $time > 2) begin
            chk("cyc_ready",  {63'd0, bus.ready_o}, {63'd0, m_ready});
            chk("cyc_result", bus.result_o, m_res);
            chk("cyc_stall",  {63'd0, bus.stall_o},
                {63'd0, (!rst && bus.start_i && !bus.annul_i && !m_ready)});
        end
    end

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int exp_lat, input int exp_stall,
                          input int hold);
        int  n;
        int  ns;
        bit  got;
        @(posedge clk); #2;
        bus.start_i   = 1'b1;
        bus.signed_i  = sgn;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        n   = 0;
        ns  = 0;
        got = 1'b0;
        #1;
        if (bus.stall_o) ns++;
        while (n < 100 && !got) begin
            @(posedge clk); n++; #1;
            if (n == 1) begin
                bus.opdata1_i = ~a;
                bus.opdata2_i = 32'd0;
            end
            if (bus.ready_o) got = 1'b1;
            else if (bus.stall_o) ns++;
        end
        chk("latency", 64'(n - 1), 64'(exp_lat));
        chk("result", bus.result_o, exp_res);
        chk("stall_cycles", 64'(ns), 64'(exp_stall));
        repeat (hold) @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        @(posedge clk); #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_i   = 1'b0;
        bus.annul_i   = 1'b0;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'd0;
        bus.opdata2_i = 32'd0;
        #1 rst = 1'b1;
        bus.start_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", bus.result_o, 64'd0);
        chk("rst_ready",  {63'd0, bus.ready_o}, 64'd0);
        chk("rst_stall",  {63'd0, bus.stall_o}, 64'd0);
        bus.start_i = 1'b0;
        #1 rst = 1'b0;

        do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 34, 0);

        // Annul during iteration
        @(posedge clk); #2;
        bus.start_i = 1'b1; bus.signed_i = 1'b0;
        bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
        repeat (11) @(posedge clk);
        #2 bus.annul_i = 1'b1;
        @(posedge clk); #2;
        bus.annul_i = 1'b0; bus.start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("annul_ready",  {63'd0, bus.ready_o}, 64'd0);
        chk("annul_result", bus.result_o, 64'h00000002_0000000E);

        do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 34, 0);

        // start and annul fall together
        @(posedge clk); #2;
        bus.start_i = 1'b1; bus.signed_i = 1'b0;
        bus.opdata1_i = 32'd500; bus.opdata2_i = 32'd5;
        repeat (5) @(posedge clk);
        #2 bus.start_i = 1'b0; bus.annul_i = 1'b1;
        @(posedge clk); #2 bus.annul_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("fall_result", bus.result_o, 64'h00000000_00000003);

        do_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33, 34, 2);
        do_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 34, 0);
        do_div(1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 33, 34, 0);
        do_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33, 34, 0);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 34, 0);

        // Async reset mid-divide
        @(posedge clk); #2;
        bus.start_i = 1'b1; bus.signed_i = 1'b0;
        bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd5;
        repeat (6) @(posedge clk);
        #6 rst = 1'b1;
        #1;
        chk("arst_result", bus.result_o, 64'd0);
        chk("arst_ready",  {63'd0, bus.ready_o}, 64'd0);
        chk("arst_stall",  {63'd0, bus.stall_o}, 64'd0);
        bus.start_i = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        do_div(1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 33, 34, 0);

        do_div(1'b1, 32'h12345678, 32'h00000000, 64'd0, 1, 2, 0);
        do_div(1'b0, 32'hDEADBEEF, 32'h00000000, 64'd0, 1, 2, 3);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_sched.md
# div_sched

Sequencing controller and iterative datapath for the MIPS DIV/DIVU instructions, sitting beside the single-cycle ALU in the execute stage. It accepts a divide request from EX, runs a 32-iteration restoring division over multiple cycles, and stalls the pipeline while busy. It delivers a 64-bit {remainder, quotient} result for the HI/LO write, and supports abort by exception/flush.

## Interface
- DATA_W, 32, operand width; the iteration count equals DATA_W.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  divide request from EX. Held high by EX until ready_o is seen.
- annul_i  in  1  flush/exception abort of the in-flight divide.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled with start.
- opdata1_i  in  32  dividend (rs). Sampled with start.
- opdata2_i  in  32  divisor (rt). Sampled with start.
- result_o  out  64  {remainder[63:32] → HI, quotient[31:0] → LO}. Registered.
- ready_o  out  1  result valid. Registered.
- stall_o  out  1  pipeline stall request. Combinational.

## Operation
- States: IDLE, BYZERO, ON, END. Reset enters IDLE with counter 0, result_o 0 and ready_o 0. stall_o is 0 while rst is high.
- IDLE, start_i=1 and annul_i=0:
  - Latch signed_i and the dividend/divisor signs.
  - If the divisor is 0, go to BYZERO.
  - Otherwise latch the magnitudes: abs() when signed, raw when unsigned. Clear the working register {rem[32:0], quo[31:0]} with quo = |dividend|, set cnt=0, and go to ON.
  - Operand changes after this capture edge are ignored.
- IDLE, start_i=0 or annul_i=1: stay in IDLE. result_o holds its value and ready_o=0.
- BYZERO: next edge goes to END with result_o = 0 (HI=0, LO=0). The MIPS result is architecturally undefined; the team fixes it at zero.
- ON, while cnt < 32, one iteration per edge:
  - Shift {rem, quo} left by 1.
  - diff = rem_shifted − divisor (33-bit).
  - If diff is non-negative, rem = diff and quo[0]=1. Otherwise rem is unchanged and quo[0]=0.
  - cnt++.
- ON, cnt == 32: apply sign correction and go to END.
  - If signed and the dividend and divisor signs differ, quotient = −quo.
  - If signed and the dividend is negative, remainder = −rem.
  - Remainder takes the dividend's sign (truncating division).
  - Negation is 32-bit two's-complement wrap. So signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
- ON, annul_i=1 or start_i=0 on any edge: return to IDLE at once. result_o is unchanged and ready_o stays 0; no END pulse.
- END: ready_o=1 and result_o is stable. Leave for IDLE on the first edge where start_i=0 or annul_i=1; ready_o clears on that edge.
- Back-to-back: start_i must drop for at least one cycle between divides, because END leaves only on start_i=0. A start_i held high in END is not a new request.
- stall_o = start_i & ~annul_i & ~ready_o.

## Timing
- Let E0 be the edge sampling start in IDLE.
  - Normal divide: iterations on E1..E32, sign fix plus the move to END on E33. ready_o is high from E33 and stall_o is high from E0's cycle through E33.
  - Divide-by-zero: BYZERO after E0, END after E1, ready_o high from E1.
- result_o and ready_o change only on clock edges and are never glitch-driven. stall_o follows start_i/annul_i combinationally, with no extra cycle.
- Asynchronous rst in any state forces IDLE, cnt=0, result_o=0 and ready_o=0 immediately, independent of clk.
- annul_i and start_i fall on the same edge: handled as one abort, with no double transition.

## Test plan
- DIVU 100 / 7: ready_o rises exactly 33 edges after E0; result_o = {0x00000002, 0x0000000E}; stall_o high for 34 cycles, then low.
- DIV −7 / 2 (0xFFFFFFF9, 0x00000002): result {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7 / −2: result {0x00000001, 0xFFFFFFFD}. DIVU 0xFFFFFFF9 / 2: result {0x00000001, 0x7FFFFFFC}.
- DIV 0x80000000 / 0xFFFFFFFF: result {0x00000000, 0x80000000}, with no hang and no X.
- Divisor 0, both signed and unsigned: ready_o high 1 edge after E0 entry into BYZERO (at E1); result_o = 0.
- annul_i pulse at iteration 10: IDLE on that edge; ready_o never rises; result_o keeps its previous value. A fresh DIVU 9/3 then gives {0, 3} at E33.
- Async rst asserted mid-ON, between edges: outputs are 0 immediately. After release, start_i with DIVU 0xFFFFFFFF / 1 gives {0, 0xFFFFFFFF}.
